note_detector: RTL and testbench

Measures the period of an incoming square-wave tone and decodes it back to the 4-bit note index used by the tone generator (note 0..F). This is the receive side of the audio path. It sits after the speaker/tone line, either in loopback for self-test or on a line-in from another board. It reports a note only after two consecutive matching half-period measurements, and flags silence on timeout.

---
 rtl/note_detect_pkg.sv | 20 ++
 rtl/tone_period_counter.sv | 54 +++++
 rtl/note_detector.sv | 123 ++++++++++++
 tb/tb_note_detector.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/note_detect_pkg.sv
// Shared constants and types for the tone-period note detector.
package note_detect_pkg;

    // Saturation value of the default 17-bit half-period counter.
    localparam int unsigned CNT_MAX = 131071;

    // Nominal half periods in clk cycles (generator frequency value + 1), note 0..F.
    localparam int unsigned NOTE_HALF_PERIOD [16] = '{
        113636, 107258, 101238, 95556, 90193, 85131, 80353, 75843,
        71586,  67569,  63776,  60197, 56818, 53629, 50619, 47778
    };

    typedef enum logic [1:0] {
        StIdle,
        StMeasure,
        StLocking,
        StLocked
    } det_state_e;

endpackage

// File: rtl/tone_period_counter.sv
// Synchronizes the tone input, detects both transitions and measures the
// spacing between them with a saturating counter.
module tone_period_counter #(
    parameter int unsigned CNT_W = 17
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone,
    output logic             edge_pulse,
    output logic [CNT_W-1:0] h_meas,
    output logic             timeout
);

    localparam logic [CNT_W-1:0] CntSat = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CntOne = {{(CNT_W-1){1'b0}}, 1'b1};

    logic             sync1_q;
    logic             sync2_q;
    logic             sync3_q;
    logic             edge_q;
    logic [CNT_W-1:0] cnt_q;

    // Two-flop synchronizer, a history flop and a registered any-edge pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            sync3_q <= 1'b0;
            edge_q  <= 1'b0;
        end else begin
            sync1_q <= tone;
            sync2_q <= sync1_q;
            sync3_q <= sync2_q;
            edge_q  <= sync2_q ^ sync3_q;
        end
    end

    // Half-period counter: restarts at 1 after an edge, otherwise counts up and sticks at full scale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (edge_q) begin
            cnt_q <= CntOne;
        end else if (cnt_q != CntSat) begin
            cnt_q <= cnt_q + CntOne;
        end
    end

    // The capture is the count standing on the edge cycle.
    assign edge_pulse = edge_q;
    assign h_meas     = cnt_q;
    assign timeout    = (cnt_q == CntSat);

endmodule

// File: rtl/note_detector.sv
// Decodes a square-wave tone back to its 4-bit note index, locking only after
// two consecutive half-period measurements fall in the same note window.
module note_detector
    import note_detect_pkg::*;
#(
    parameter int unsigned CNT_W       = 17,
    parameter int unsigned TOL_SHIFT   = 6,
    // Right-shift of the nominal table; nonzero retargets to a proportionally faster tone source.
    parameter int unsigned TABLE_SHIFT = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tone,
    output logic [3:0]       note,
    output logic             valid,
    output logic             note_strobe,
    output logic [CNT_W-1:0] period
);

    logic             edge_pulse;
    logic [CNT_W-1:0] h_meas;
    logic             timeout;

    tone_period_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk        (clk),
        .rst        (rst),
        .tone       (tone),
        .edge_pulse (edge_pulse),
        .h_meas     (h_meas),
        .timeout    (timeout)
    );

    logic [31:0] h_ext;
    logic [15:0] win_hit;
    logic        hit;
    logic [3:0]  hit_idx;

    assign h_ext = 32'(h_meas);

    // One tolerance window per note; windows are disjoint so at most one fires.
    for (genvar k = 0; k < 16; k++) begin : g_win
        localparam int unsigned Nom = NOTE_HALF_PERIOD[k] >> TABLE_SHIFT;
        localparam int unsigned Tol = Nom >> TOL_SHIFT;
        assign win_hit[k] = (h_ext >= (Nom - Tol)) && (h_ext <= (Nom + Tol));
    end

    // Priority encode the window hits (lowest index wins).
    always_comb begin
        hit     = 1'b0;
        hit_idx = '0;
        for (int k = 15; k >= 0; k--) begin
            if (win_hit[k]) begin
                hit     = 1'b1;
                hit_idx = 4'(k);
            end
        end
    end

    det_state_e state_q;
    logic [3:0] cand_q;

    // Lock FSM with registered outputs; saturation overrides any coincident edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cand_q      <= '0;
            note        <= '0;
            valid       <= 1'b0;
            note_strobe <= 1'b0;
            period      <= '0;
        end else begin
            note_strobe <= 1'b0;
            if (timeout) begin
                state_q <= StIdle;
                valid   <= 1'b0;
                cand_q  <= '0;
            end else if (edge_pulse) begin
                case (state_q)
                    // First capture after silence covers a partial period.
                    StIdle: state_q <= StMeasure;
                    StMeasure: begin
                        if (hit) begin
                            cand_q  <= hit_idx;
                            state_q <= StLocking;
                        end
                    end
                    StLocking: begin
                        if (!hit) begin
                            state_q <= StMeasure;
                        end else begin
                            period <= h_meas;
                            if (hit_idx == cand_q) begin
                                state_q     <= StLocked;
                                valid       <= 1'b1;
                                note        <= hit_idx;
                                note_strobe <= 1'b1;
                            end else begin
                                cand_q <= hit_idx;
                            end
                        end
                    end
                    StLocked: begin
                        if (!hit) begin
                            valid   <= 1'b0;
                            state_q <= StMeasure;
                        end else begin
                            period <= h_meas;
                            if (hit_idx != cand_q) begin
                                valid   <= 1'b0;
                                cand_q  <= hit_idx;
                                state_q <= StLocking;
                            end
                        end
                    end
                    default: state_q <= StIdle;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_note_detector.sv
// Self-checking bench for note_detector, run with a scaled-down note table so
// every scenario fits in a short simulation.
module tb_note_detector;

    localparam int CNT_W       = 10;
    localparam int TABLE_SHIFT = 7;
    localparam int TOL_SHIFT   = 6;
    localparam int CNTMAX      = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             tone = 1'b0;
    logic [3:0]       note;
    logic             valid;
    logic             note_strobe;
    logic [CNT_W-1:0] period;

    note_detector #(
        .CNT_W       (CNT_W),
        .TOL_SHIFT   (TOL_SHIFT),
        .TABLE_SHIFT (TABLE_SHIFT)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tone        (tone),
        .note        (note),
        .valid       (valid),
        .note_strobe (note_strobe),
        .period      (period)
    );

    always #5 clk = ~clk;

    int passed = 0;
    int total  = 0;
    int strobe_cnt = 0;
    int since = 0;

    // Edge-level reference model.
    int m_armed = 0;
    int m_cand = -1;
    int m_locked = 0;
    int m_note = 0;
    int m_period = 0;
    int m_strobes = 0;

    // Generator frequency values + 1, scaled by the same shift as the DUT.
    int freq_tab [16] = '{113636, 107258, 101238, 95556, 90193, 85131, 80353, 75843,
                          71586, 67569, 63776, 60197, 56818, 53629, 50619, 47778};

    function automatic int nom(input int k);
        return freq_tab[k] >> TABLE_SHIFT;
    endfunction

    function automatic int classify(input int h);
        for (int k = 0; k < 16; k++) begin
            int n;
            int tol;
            n = nom(k);
            tol = n >> TOL_SHIFT;
            if (h >= n - tol && h <= n + tol) return k;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    endtask

    task automatic model_idle();
        m_armed = 0;
        m_cand = -1;
        m_locked = 0;
    endtask

    // One tone transition that closed a half period of h cycles.
    task automatic model_edge(input int h);
        int k;
        int tracking;
        if (h >= CNTMAX) begin
            model_idle();
            return;
        end
        if (m_armed == 0) begin
            m_armed = 1;
            m_cand = -1;
            m_locked = 0;
            return;
        end
        k = classify(h);
        tracking = (m_locked != 0 || m_cand >= 0) ? 1 : 0;
        if (k < 0) begin
            m_locked = 0;
            m_cand = -1;
        end else begin
            if (tracking != 0) m_period = h;
            if (m_locked != 0 && k == m_note) begin
                m_cand = k;
            end else if (m_locked == 0 && k == m_cand) begin
                m_locked = 1;
                m_note = k;
                m_strobes++;
            end else begin
                m_locked = 0;
                m_cand = k;
            end
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, "_valid"}, int'(valid), m_locked);
        chk({tag, "_note"}, int'(note), m_note);
        chk({tag, "_period"}, int'(period), m_period);
        chk({tag, "_strobes"}, strobe_cnt, m_strobes);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            since++;
        end
    endtask

    // Toggle the tone now, then hold it for d cycles.
    task automatic step(input int d);
        tone = ~tone;
        model_edge(since);
        since = 0;
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            since++;
            if (i == 6) check_all("edge");
        end
        if (since >= CNTMAX + 7) begin
            model_idle();
            check_all("silence");
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #1;
        chk("rst_valid", int'(valid), 0);
        chk("rst_note", int'(note), 0);
        chk("rst_strobe", int'(note_strobe), 0);
        chk("rst_period", int'(period), 0);
        tone = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        model_idle();
        m_note = 0;
        m_period = 0;
        since = 0;
    endtask

    // Every strobe is counted and must coincide with valid.
    always @(negedge clk) begin
        if (!rst && note_strobe === 1'b1) begin
            strobe_cnt++;
            chk("strobe_while_valid", int'(valid), 1);
        end
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        int k;
        int n;
        int tol;
        int d;
        int edges;
        int mode;

        repeat (3) @(negedge clk);
        do_reset();

        // Loopback note 9 from reset.
        idle(5);
        repeat (3) step(nom(9));
        chk("t1_valid", int'(valid), 1);
        chk("t1_note", int'(note), 9);
        chk("t1_period", int'(period), nom(9));
        chk("t1_strobes", strobe_cnt, 1);

        // Lock on 3, then switch to C.
        repeat (3) step(nom(3));
        chk("t2_lock3", int'(note), 3);
        step(nom(12));
        step(nom(12));
        chk("t2_drop", int'(valid), 0);
        step(nom(12));
        chk("t2_relock_valid", int'(valid), 1);
        chk("t2_relock_note", int'(note), 12);

        // Lock on 0, then go silent past saturation.
        repeat (3) step(nom(0));
        chk("t3_locked", int'(valid), 1);
        step(CNTMAX + 17);
        chk("t3_timeout_valid", int'(valid), 0);
        chk("t3_note_hold", int'(note), 0);

        // Half period between note 1 and note 2 windows never locks.
        do_reset();
        idle(5);
        repeat (6) step(104000 >> TABLE_SHIFT);
        chk("t4_valid", int'(valid), 0);
        chk("t4_period", int'(period), 0);

        // One-cycle jitter around note F holds the lock with a single strobe.
        s0 = strobe_cnt;
        for (int i = 0; i < 10; i++) step((i % 2 == 0) ? nom(15) - 1 : nom(15) + 1);
        chk("t5_valid", int'(valid), 1);
        chk("t5_note", int'(note), 15);
        chk("t5_one_strobe", strobe_cnt - s0, 1);

        // Reset in the middle of a lock on 5, then re-lock.
        repeat (3) step(nom(5));
        chk("t6_pre_valid", int'(valid), 1);
        do_reset();
        idle(5);
        repeat (3) step(nom(5));
        chk("t6_relock_valid", int'(valid), 1);
        chk("t6_relock_note", int'(note), 5);

        // Random segments: in-window, exact window edges, just outside, arbitrary.
        for (int seg = 0; seg < 15; seg++) begin
            k = int'($urandom_range(15));
            n = nom(k);
            tol = n >> TOL_SHIFT;
            edges = int'($urandom_range(4, 1));
            for (int e = 0; e < edges; e++) begin
                mode = int'($urandom_range(5));
                case (mode)
                    0: d = int'($urandom_range(1000, 300));
                    1: d = n + tol;
                    2: d = n - tol;
                    3: d = n + tol + 1;
                    default: d = n - tol + int'($urandom_range(2 * tol));
                endcase
                step(d);
            end
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
